// File: rtl/alarm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alarm_ctrl_pkg
// Shared definitions for the multi-alarm set controller:
//   - state_e    : controller states; the numeric values are what MODE shows
//                  to the display mux.
//   - MODE_W     : width of the MODE output.
//   - sel_width  : width of the alarm-select index for a given alarm count.
//   - next_mode  : the F1 (mode/advance) state sequence.
// -----------------------------------------------------------------------------
package alarm_ctrl_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SEL      = 3'd1,
        ST_SETHOUR  = 3'd2,
        ST_SETMIN   = 3'd3,
        ST_SETONOFF = 3'd4
    } state_e;

    // A single alarm still needs a one-bit select port.
    function automatic int sel_width(input int num_alarms);
        return (num_alarms <= 1) ? 1 : $clog2(num_alarms);
    endfunction

    function automatic state_e next_mode(input state_e s);
        state_e nm;
        nm = ST_IDLE;
        case (s)
            ST_IDLE:     nm = ST_SEL;
            ST_SEL:      nm = ST_SETHOUR;
            ST_SETHOUR:  nm = ST_SETMIN;
            ST_SETMIN:   nm = ST_SETONOFF;
            ST_SETONOFF: nm = ST_IDLE;
            default:     nm = ST_IDLE;
        endcase
        return nm;
    endfunction

endpackage

// File: rtl/alarm_control_multi_sw_edge_repeat.sv
// -----------------------------------------------------------------------------
// sw_edge_repeat
// Rising-edge detector with optional auto-repeat for one debounced switch.
//   clock, reset : system clock, asynchronous active-high reset
//   sw           : debounced switch level (synchronous to clock)
//   repeat_en    : auto-repeat permitted at this edge; dropping it disarms
//                  the repeat until the switch is released and pressed again
//   rise         : combinational, high at the edge where sw is sampled 1 after
//                  being sampled 0
//   rpt_pulse    : combinational, high at hold counts REPEAT_DELAY,
//                  REPEAT_DELAY+REPEAT_RATE, REPEAT_DELAY+2*REPEAT_RATE, ...
// -----------------------------------------------------------------------------
module sw_edge_repeat #(
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic sw,
    input  logic repeat_en,
    output logic rise,
    output logic rpt_pulse
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);

    // was_low_q is the previous-sample register stored inverted: clearing it on
    // reset makes a switch that is already high at release look "still held",
    // so no rise is reported until it has been sampled low.
    logic             was_low_q, was_low_d;
    logic             armed_q, armed_d;
    // The counter measures the initial delay first, then restarts for every
    // repeat interval, so it never has to count beyond max(DELAY, RATE).
    logic             rate_phase_q, rate_phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             target_hit;

    always_comb begin
        was_low_d    = ~sw;
        rise         = sw & was_low_q;
        cnt_inc      = cnt_q + 1'b1;
        target_hit   = rate_phase_q ? (cnt_inc == RATE_C) : (cnt_inc == DELAY_C);
        rpt_pulse    = 1'b0;
        armed_d      = 1'b0;
        rate_phase_d = 1'b0;
        cnt_d        = '0;
        if (sw && repeat_en) begin
            if (rise) begin
                armed_d = 1'b1;
            end else if (armed_q) begin
                armed_d = 1'b1;
                if (target_hit) begin
                    rpt_pulse    = 1'b1;
                    rate_phase_d = 1'b1;
                end else begin
                    rate_phase_d = rate_phase_q;
                    cnt_d        = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            was_low_q    <= 1'b0;
            armed_q      <= 1'b0;
            rate_phase_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            was_low_q    <= was_low_d;
            armed_q      <= armed_d;
            rate_phase_q <= rate_phase_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_control_multi.sv
// -----------------------------------------------------------------------------
// alarm_control_multi
// Front-panel controller for NUM_ALARMS alarm channels using two switches.
//   clock, reset : system clock, asynchronous active-high reset
//   SW_F1        : mode/advance switch (debounced level)
//   SW_F2        : increment/toggle switch (debounced level)
//   ALM_SEL      : selected alarm index
//   ALM_HOUR     : one-cycle hour-increment pulse for alarm ALM_SEL
//   ALM_MIN      : one-cycle minute-increment pulse for alarm ALM_SEL
//   ALM_ONOFF    : one-cycle pulse when the enable of ALM_SEL toggles
//   ALM_ENA      : held enable bit per alarm
//   MODE         : current state (IDLE=0 SEL=1 SETHOUR=2 SETMIN=3 SETONOFF=4)
// All outputs are registered; a switch edge is reflected one cycle later.
// -----------------------------------------------------------------------------
module alarm_control_multi
    import alarm_ctrl_pkg::*;
#(
    parameter int NUM_ALARMS   = 4,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_RATE  = 100000,
    parameter int TIMEOUT      = 10000000
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 SW_F1,
    input  logic                                 SW_F2,
    output logic [sel_width(NUM_ALARMS)-1:0]     ALM_SEL,
    output logic                                 ALM_HOUR,
    output logic                                 ALM_MIN,
    output logic                                 ALM_ONOFF,
    output logic [NUM_ALARMS-1:0]                ALM_ENA,
    output logic [MODE_W-1:0]                    MODE
);

    localparam int SEL_W = sel_width(NUM_ALARMS);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_ALARMS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_ALARMS-1:0]   ena_q, ena_d;
    logic                    hour_q, hour_d;
    logic                    min_q, min_d;
    logic                    onoff_q, onoff_d;
    logic [TO_W-1:0]         to_q, to_d;

    logic f1_rise, f1_rpt;
    logic f2_rise, f2_rpt, f2_rpt_en;
    logic f2_act, activity, timed_out;

    // An F1 rise on the same edge keeps F2 from arming, so a held F2 cannot
    // start repeating in the state F1 moves to.
    assign f2_rpt_en = ((state_q == ST_SETHOUR) || (state_q == ST_SETMIN)) && !f1_rise;

    sw_edge_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_f1 (
        .clock     (clock),
        .reset     (reset),
        .sw        (SW_F1),
        .repeat_en (1'b0),
        .rise      (f1_rise),
        .rpt_pulse (f1_rpt)
    );

    sw_edge_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_f2 (
        .clock     (clock),
        .reset     (reset),
        .sw        (SW_F2),
        .repeat_en (f2_rpt_en),
        .rise      (f2_rise),
        .rpt_pulse (f2_rpt)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ena_d   = ena_q;
        hour_d  = 1'b0;
        min_d   = 1'b0;
        onoff_d = 1'b0;
        to_d    = to_q;

        f2_act    = f2_rise && !f1_rise;
        activity  = f1_rise || f1_rpt || f2_rise || f2_rpt;
        // Any switch activity on the expiring edge wins over the timeout.
        timed_out = (state_q != ST_IDLE) && !activity && (to_q == TO_LAST);

        if (f1_rise) begin
            state_d = next_mode(state_q);
        end else if (timed_out) begin
            state_d = ST_IDLE;
        end else if (f2_act || f2_rpt) begin
            case (state_q)
                ST_SEL:      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                ST_SETHOUR:  hour_d = 1'b1;
                ST_SETMIN:   min_d  = 1'b1;
                ST_SETONOFF: begin
                    for (int i = 0; i < NUM_ALARMS; i++) begin
                        if (sel_q == SEL_W'(i)) ena_d[i] = ~ena_q[i];
                    end
                    onoff_d = 1'b1;
                end
                default: ;
            endcase
        end

        if ((state_d == ST_IDLE) || activity) begin
            to_d = '0;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ena_q   <= '0;
            hour_q  <= 1'b0;
            min_q   <= 1'b0;
            onoff_q <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ena_q   <= ena_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            onoff_q <= onoff_d;
            to_q    <= to_d;
        end
    end

    assign ALM_SEL   = sel_q;
    assign ALM_HOUR  = hour_q;
    assign ALM_MIN   = min_q;
    assign ALM_ONOFF = onoff_q;
    assign ALM_ENA   = ena_q;
    assign MODE      = state_q;

endmodule

// File: tb/tb_alarm_control_multi.sv
module tb_alarm_control_multi;

    localparam int N = 3;
    localparam int D = 8;
    localparam int R = 4;
    localparam int T = 50;

    logic       clock, reset, SW_F1, SW_F2;
    logic [1:0] ALM_SEL;
    logic       ALM_HOUR, ALM_MIN, ALM_ONOFF;
    logic [2:0] ALM_ENA;
    logic [2:0] MODE;

    alarm_control_multi #(
        .NUM_ALARMS   (N),
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R),
        .TIMEOUT      (T)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .SW_F1     (SW_F1),
        .SW_F2     (SW_F2),
        .ALM_SEL   (ALM_SEL),
        .ALM_HOUR  (ALM_HOUR),
        .ALM_MIN   (ALM_MIN),
        .ALM_ONOFF (ALM_ONOFF),
        .ALM_ENA   (ALM_ENA),
        .MODE      (MODE)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Mode is a plain 0..4 counter; the hold time h is an unbounded count of
    // cycles since the F2 rise; idle counts quiet cycles outside IDLE.
    int       m_mode, m_sel, m_h, m_idle;
    bit       m_hv, m_p1, m_p2, m_hour, m_min, m_onoff;
    bit [N-1:0] m_ena;

    function automatic void model_reset();
        m_mode = 0; m_sel = 0; m_h = 0; m_idle = 0; m_hv = 0;
        m_p1 = 1; m_p2 = 1;  // a switch high at release must first be seen low
        m_hour = 0; m_min = 0; m_onoff = 0; m_ena = '0;
    endfunction

    function automatic void model_step(input bit f1, input bit f2);
        bit r1, r2, rpt, act, setting;
        r1 = f1 && !m_p1;
        r2 = f2 && !m_p2;
        setting = (m_mode == 2) || (m_mode == 3);
        rpt = 0;
        m_hour = 0; m_min = 0; m_onoff = 0;
        if (!f2) m_hv = 0;
        else if (r2) begin
            m_h = 0;
            m_hv = setting && !r1;
        end else if (m_hv) begin
            if (r1 || !setting) m_hv = 0;
            else begin
                m_h++;
                rpt = (m_h == D) || (m_h > D && ((m_h - D) % R) == 0);
            end
        end
        act = r1 || r2 || rpt;
        if (r1) m_mode = (m_mode + 1) % 5;
        else if (r2 || rpt) begin
            case (m_mode)
                1: m_sel = (m_sel + 1) % N;
                2: m_hour = 1;
                3: m_min = 1;
                4: begin m_ena[m_sel] = !m_ena[m_sel]; m_onoff = 1; end
                default: ;
            endcase
        end else if (m_mode != 0) begin
            m_idle++;
            if (m_idle == T) m_mode = 0;
        end
        if (act || m_mode == 0) m_idle = 0;
        m_p1 = f1;
        m_p2 = f2;
    endfunction

    // Inputs change just after the falling edge; outputs are read there too.
    task automatic step(input bit f1, input bit f2);
        SW_F1 = f1;
        SW_F2 = f2;
        @(posedge clock);
        model_step(f1, f2);
        @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/MODE"},  32'(MODE),      32'(m_mode));
        chk({tag, "/SEL"},   32'(ALM_SEL),   32'(m_sel));
        chk({tag, "/HOUR"},  32'(ALM_HOUR),  32'(m_hour));
        chk({tag, "/MIN"},   32'(ALM_MIN),   32'(m_min));
        chk({tag, "/ONOFF"}, 32'(ALM_ONOFF), 32'(m_onoff));
        chk({tag, "/ENA"},   32'(ALM_ENA),   32'(m_ena));
    endtask

    task automatic stepc(input bit f1, input bit f2, input string tag);
        step(f1, f2);
        check_model(tag);
    endtask

    // Reset is raised between clock edges and the outputs are read before the
    // next rising edge, so only an asynchronous clear can satisfy the checks.
    task automatic do_reset(input bit f1_lvl, input string tag);
        SW_F1 = f1_lvl;
        SW_F2 = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk({tag, "/MODE"},  32'(MODE),      32'd0);
        chk({tag, "/SEL"},   32'(ALM_SEL),   32'd0);
        chk({tag, "/HOUR"},  32'(ALM_HOUR),  32'd0);
        chk({tag, "/MIN"},   32'(ALM_MIN),   32'd0);
        chk({tag, "/ONOFF"}, 32'(ALM_ONOFF), 32'd0);
        chk({tag, "/ENA"},   32'(ALM_ENA),   32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit       f1;
        bit       f2;
        bit [2:0] mode;
        bit [1:0] sel;
        bit       hour;
        bit       min;
        bit       onoff;
        bit [2:0] ena;
    } vec_t;

    function automatic vec_t mk(bit f1, bit f2, bit [2:0] mode, bit [1:0] sel,
                                bit hour, bit min, bit onoff, bit [2:0] ena);
        vec_t v;
        v.f1 = f1; v.f2 = f2; v.mode = mode; v.sel = sel;
        v.hour = hour; v.min = min; v.onoff = onoff; v.ena = ena;
        return v;
    endfunction

    initial begin
        vec_t vt[$];
        bit [19:0] got_mask, exp_mask;
        int cnt_a, cnt_b;
        int f2_left;
        bit f2_lvl;
        bit f1r;

        // {F1, F2} applied for one edge -> outputs during the following cycle
        vt.push_back(mk(1,0, 1,0, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 1,0, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 1,1, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 1,1, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 1,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 1,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 1,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 1,0, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 1,0, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 1,1, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 1,1, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 1,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 1,2, 0,0,0, 3'b000));
        vt.push_back(mk(1,0, 2,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 2,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 2,2, 1,0,0, 3'b000));
        vt.push_back(mk(0,0, 2,2, 0,0,0, 3'b000));
        vt.push_back(mk(1,0, 3,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 3,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 3,2, 0,1,0, 3'b000));
        vt.push_back(mk(0,0, 3,2, 0,0,0, 3'b000));
        vt.push_back(mk(1,0, 4,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,0, 4,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 4,2, 0,0,1, 3'b100));
        vt.push_back(mk(0,0, 4,2, 0,0,0, 3'b100));
        vt.push_back(mk(0,1, 4,2, 0,0,1, 3'b000));
        vt.push_back(mk(0,0, 4,2, 0,0,0, 3'b000));
        vt.push_back(mk(0,1, 4,2, 0,0,1, 3'b100));
        vt.push_back(mk(0,0, 4,2, 0,0,0, 3'b100));
        vt.push_back(mk(1,0, 0,2, 0,0,0, 3'b100));
        vt.push_back(mk(0,0, 0,2, 0,0,0, 3'b100));
        vt.push_back(mk(0,1, 0,2, 0,0,0, 3'b100));
        vt.push_back(mk(0,0, 0,2, 0,0,0, 3'b100));

        reset = 1'b0;
        SW_F1 = 1'b0;
        SW_F2 = 1'b0;
        @(negedge clock);
        do_reset(1'b0, "rst0");
        stepc(0, 0, "post_rst0");

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].f1, vt[i].f2);
            chk($sformatf("vec%0d/MODE", i),  32'(MODE),      32'(vt[i].mode));
            chk($sformatf("vec%0d/SEL", i),   32'(ALM_SEL),   32'(vt[i].sel));
            chk($sformatf("vec%0d/HOUR", i),  32'(ALM_HOUR),  32'(vt[i].hour));
            chk($sformatf("vec%0d/MIN", i),   32'(ALM_MIN),   32'(vt[i].min));
            chk($sformatf("vec%0d/ONOFF", i), 32'(ALM_ONOFF), 32'(vt[i].onoff));
            chk($sformatf("vec%0d/ENA", i),   32'(ALM_ENA),   32'(vt[i].ena));
        end

        // Async reset mid-state with F1 held high through the release
        stepc(1, 0, "pre_rst1");
        do_reset(1'b1, "rst_mid");
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            chk("f1_held_after_rst/MODE", 32'(MODE), 32'd0);
        end
        stepc(0, 0, "f1_low");
        step(1, 0);
        chk("f1_rise_after_low/MODE", 32'(MODE), 32'd1);

        // Timeout from SEL with ALM_SEL retained
        stepc(0, 1, "to_sel_inc");
        for (int i = 0; i < T - 1; i++) stepc(0, 0, "to_wait");
        chk("to_before/MODE", 32'(MODE), 32'd1);
        stepc(0, 0, "to_expire");
        chk("to_after/MODE", 32'(MODE), 32'd0);
        chk("to_after/SEL", 32'(ALM_SEL), 32'd1);

        // Activity at quiet cycle 49 restarts the timeout
        stepc(1, 0, "to2_enter");
        for (int i = 0; i < T - 2; i++) stepc(0, 0, "to2_wait");
        stepc(0, 1, "to2_kick");
        for (int i = 0; i < T - 1; i++) stepc(0, 0, "to2_wait2");
        chk("to2_before/MODE", 32'(MODE), 32'd1);
        stepc(0, 0, "to2_expire");
        chk("to2_after/MODE", 32'(MODE), 32'd0);
        chk("to2_after/SEL", 32'(ALM_SEL), 32'd2);

        // Auto-repeat in SETHOUR
        stepc(1, 0, "ar_sel");
        stepc(0, 0, "ar_q");
        stepc(1, 0, "ar_hour");
        stepc(0, 0, "ar_q2");
        got_mask = '0;
        exp_mask = '0;
        for (int i = 0; i < 20; i++) begin
            stepc(0, 1, "ar_hold");
            got_mask[i] = ALM_HOUR;
            exp_mask[i] = (i == 0) || (i >= D && ((i - D) % R) == 0);
        end
        chk("ar_hour_positions", 32'(got_mask), 32'(exp_mask));
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            stepc(0, 0, "ar_release");
            cnt_a += int'(ALM_HOUR);
        end
        chk("ar_release_pulses", 32'(cnt_a), 32'd0);

        // F1 rise while F2 is held in SETHOUR
        stepc(0, 1, "f1h_press");
        chk("f1h_press/HOUR", 32'(ALM_HOUR), 32'd1);
        for (int i = 0; i < 3; i++) stepc(0, 1, "f1h_hold");
        stepc(1, 1, "f1h_adv");
        chk("f1h_adv/MODE", 32'(MODE), 32'd3);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 15; i++) begin
            stepc(0, 1, "f1h_still");
            cnt_a += int'(ALM_MIN);
            cnt_b += int'(ALM_HOUR);
        end
        chk("f1h_min_pulses", 32'(cnt_a), 32'd0);
        chk("f1h_hour_pulses", 32'(cnt_b), 32'd0);
        stepc(0, 0, "f1h_rel");

        // Simultaneous F1+F2 rise in SETMIN
        stepc(1, 1, "sim_rise");
        chk("sim_rise/MODE", 32'(MODE), 32'd4);
        chk("sim_rise/MIN", 32'(ALM_MIN), 32'd0);
        cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            stepc(0, 1, "sim_hold");
            cnt_a += int'(ALM_ONOFF);
        end
        chk("sim_onoff_pulses", 32'(cnt_a), 32'd0);
        stepc(0, 0, "sim_rel");
        stepc(1, 0, "sim_exit");
        chk("sim_exit/MODE", 32'(MODE), 32'd0);

        // Randomised run against the model
        f2_left = 0;
        f2_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (f2_left == 0) begin
                f2_lvl = ~f2_lvl;
                f2_left = f2_lvl ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 6));
            end
            f2_left--;
            f1r = ($urandom_range(0, 11) == 0);
            if (i == 1500) do_reset(f1r, "rst_rand");
            stepc(f1r, f2_lvl, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
